// File: rtl/hit_rate_monitor.sv
// hit_rate_monitor: counts hits per window of WINDOW_TICKS clk40K edges and latches results with an ack handshake.
// Optional threshold alarm enabled by defining HIT_RATE_THRESHOLD_EN.
module hit_rate_monitor #(
  parameter int WINDOW_TICKS = 40,
  parameter int COUNT_WIDTH = 24
`ifdef HIT_RATE_THRESHOLD_EN
  ,
  parameter logic [COUNT_WIDTH-1:0] THRESHOLD = COUNT_WIDTH'(100000)
`endif
) (
  input  logic                   clk40M,
  input  logic                   rst,
  input  logic                   clk40K,
  input  logic                   enable,
  input  logic                   hit_in,
  input  logic                   rate_ack,
  output logic [COUNT_WIDTH-1:0] rate_count,
  output logic                   rate_valid,
  output logic                   rate_sat,
  output logic                   rate_missed,
  output logic                   rate_alarm
);
  typedef enum logic [1:0] {IDLE, ARM, COUNT} state_t;
  state_t state, state_n;
  logic clk40K_q, tick, full, last, counting, close, latch, sat, sat_fin, sat_n;
  logic [COUNT_WIDTH-1:0] acc, acc_fin, acc_n;
  logic [15:0] tcnt, tcnt_n;
  always_comb begin
    tick = clk40K & ~clk40K_q;
    full = &acc;
    acc_fin = acc + {{(COUNT_WIDTH-1){1'b0}}, hit_in & ~full};
    sat_fin = sat | (hit_in & full);
    last = tick && (({1'b0, tcnt} + 17'd1) == 17'(WINDOW_TICKS));
    counting = enable && state == COUNT;
    close = counting && last;
    latch = close && (!rate_valid || rate_ack);
    state_n = !enable ? IDLE : state == IDLE ? ARM : (state == ARM && tick) ? COUNT : state;
    acc_n = (counting && !last) ? acc_fin : '0;
    sat_n = counting && !last && sat_fin;
    tcnt_n = (counting && !last) ? tcnt + {15'd0, tick} : 16'd0;
  end
  always_ff @(posedge clk40M or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      clk40K_q <= 1'b0;
      acc <= '0;
      sat <= 1'b0;
      tcnt <= 16'd0;
      rate_count <= '0;
      rate_valid <= 1'b0;
      rate_sat <= 1'b0;
      rate_missed <= 1'b0;
    end else begin
      state <= state_n;
      clk40K_q <= clk40K;
      acc <= acc_n;
      sat <= sat_n;
      tcnt <= tcnt_n;
      if (latch) begin
        rate_count <= acc_fin;
        rate_sat <= sat_fin;
        rate_valid <= 1'b1;
      end else if (close) rate_missed <= 1'b1;
      else if (rate_ack) rate_valid <= 1'b0;
    end
  end
`ifdef HIT_RATE_THRESHOLD_EN
  always_ff @(posedge clk40M or posedge rst) begin
    if (rst) rate_alarm <= 1'b0;
    else if (latch) rate_alarm <= acc_fin > THRESHOLD;
  end
`else
  assign rate_alarm = 1'b0;
`endif
endmodule

// File: tb/tb_hit_rate_monitor.sv
// tb_hit_rate_monitor: randomized and directed checks of hit_rate_monitor against a window-level reference model.
module tb_hit_rate_monitor;
  localparam int W = 2;
  localparam int CW = 10;
  localparam int MAX = (1 << CW) - 1;
  localparam int THR = 500;
`ifdef HIT_RATE_THRESHOLD_EN
  localparam bit ALARM_EN = 1'b1;
`else
  localparam bit ALARM_EN = 1'b0;
`endif
  logic clk40M = 1'b0, rst = 1'b1, clk40K = 1'b0, enable = 1'b0, hit_in = 1'b0, rate_ack = 1'b0;
  logic [CW-1:0] rate_count;
  logic rate_valid, rate_sat, rate_missed, rate_alarm;
  int n_tests = 0, n_fail = 0;
  logic [9:0] cnt10 = '0;
  int m_phase = 0, m_hits = 0, m_ticks = 0;
  bit m_prev = 0, m_valid = 0, m_sat = 0, m_missed = 0, m_alarm = 0;
  int m_count = 0;
  hit_rate_monitor #(
    .WINDOW_TICKS(W),
    .COUNT_WIDTH(CW)
`ifdef HIT_RATE_THRESHOLD_EN
    ,
    .THRESHOLD(CW'(THR))
`endif
  ) dut (
    .clk40M(clk40M),
    .rst(rst),
    .clk40K(clk40K),
    .enable(enable),
    .hit_in(hit_in),
    .rate_ack(rate_ack),
    .rate_count(rate_count),
    .rate_valid(rate_valid),
    .rate_sat(rate_sat),
    .rate_missed(rate_missed),
    .rate_alarm(rate_alarm)
  );
  always #5 clk40M = ~clk40M;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit is_closing();
    return cnt10[9] && !m_prev && m_phase == 2 && m_ticks == W - 1;
  endfunction
  // Model works on whole windows: unbounded hit total, clamped only when the result is published.
  task automatic step(input bit r, input bit e, input bit h, input bit a);
    bit k, tk, cl;
    int fin;
    rst = r;
    enable = e;
    hit_in = h;
    rate_ack = a;
    k = cnt10[9];
    clk40K = k;
    @(posedge clk40M);
    cnt10++;
    tk = k && !m_prev;
    m_prev = k;
    cl = 0;
    fin = 0;
    if (r) begin
      m_prev = 0; m_phase = 0; m_hits = 0; m_ticks = 0;
      m_valid = 0; m_sat = 0; m_missed = 0; m_alarm = 0; m_count = 0;
    end else if (!e) m_phase = 0;
    else if (m_phase == 0) m_phase = 1;
    else if (m_phase == 1) begin
      if (tk) begin m_phase = 2; m_hits = 0; m_ticks = 0; end
    end else begin
      m_hits += int'(h);
      if (tk) begin
        m_ticks++;
        if (m_ticks == W) begin cl = 1; fin = m_hits; m_hits = 0; m_ticks = 0; end
      end
    end
    if (!r) begin
      if (cl && (!m_valid || a)) begin
        m_valid = 1;
        m_count = fin > MAX ? MAX : fin;
        m_sat = fin > MAX;
        m_alarm = ALARM_EN && fin > THR;
      end else if (cl) m_missed = 1;
      else if (a) m_valid = 0;
    end
    #1;
    check("outs", {rate_count, rate_valid, rate_sat, rate_missed, rate_alarm},
          {CW'(m_count), m_valid, m_sat, m_missed, m_alarm});
  endtask
  function automatic bit gen(input int mode);
    return mode == 0 ? cnt10[1:0] == 2'd0 : mode == 1 ? (cnt10[1:0] == 2'd1 || is_closing()) :
           mode == 2 ? 1'b1 : cnt10[1:0] == 2'd1;
  endfunction
  task automatic step_m(input int mode, input bit a);
    step(0, 1, gen(mode), a);
  endtask
  task automatic wait_valid(input int mode, output int n);
    n = 0;
    while (!rate_valid && n < 4000) begin step_m(mode, 0); n++; end
    check("valid_timeout", rate_valid, 1);
  endtask
  initial begin
    int n;
    bit cl;
    repeat (3) step(1, 0, 0, 0);
    check("rst_count", rate_count, 0);
    check("rst_flags", {rate_valid, rate_sat, rate_missed, rate_alarm}, 0);
    wait_valid(0, n);
    check("first_512", rate_count, 512);
    check("first_sat", rate_sat, 0);
    check("first_alarm", rate_alarm, ALARM_EN);
    step_m(0, 1);
    check("ack_clears", rate_valid, 0);
    wait_valid(0, n);
    check("second_512", rate_count, 512);
    step_m(1, 1);
    wait_valid(1, n);
    step_m(1, 1);
    wait_valid(1, n);
    check("close_hit_513", rate_count, 513);
    step_m(3, 1);
    wait_valid(3, n);
    check("after_close_512", rate_count, 512);
    n = 0;
    while (!rate_missed && n < 4000) begin step_m(3, 0); n++; end
    check("missed_set", rate_missed, 1);
    check("kept_result", rate_count, 512);
    check("kept_valid", rate_valid, 1);
    cl = 0;
    n = 0;
    while (!cl && n < 4000) begin cl = is_closing(); step_m(2, 0); n++; end
    cl = 0;
    n = 0;
    while (!cl && n < 4000) begin cl = is_closing(); step_m(2, cl); n++; end
    check("ack_close_valid", rate_valid, 1);
    check("sat_count", rate_count, MAX);
    check("sat_flag", rate_sat, 1);
    check("missed_sticky", rate_missed, 1);
    step_m(0, 1);
    repeat (500) step_m(0, 0);
    repeat (50) step(0, 0, 1, 0);
    check("drop_no_latch", rate_valid, 0);
    wait_valid(0, n);
    check("resume_latency", n > 2048 && n <= 3076, 1);
    check("resume_512", rate_count, 512);
    repeat (500) step_m(0, 0);
    step(1, 1, 1, 0);
    check("rst_mid_outs", {rate_count, rate_valid, rate_sat, rate_missed, rate_alarm}, 0);
    wait_valid(0, n);
    check("rst_resume_latency", n > 2048 && n <= 3076, 1);
    check("rst_resume_512", rate_count, 512);
    for (int i = 0; i < 20000; i++)
      step($urandom_range(2999) == 0, $urandom_range(799) != 0,
           $urandom_range(3) == 0, $urandom_range(7) == 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
